// File: rtl/serdesphy_link_seq.sv
// SerDes PHY link bring-up sequencer: PLL reset/lock, TX enable, CDR reset/lock and
// RX alignment, with bounded per-stage timeouts, retry accounting and a sticky fault.
module serdesphy_link_seq #(
   parameter int unsigned SETTLE_CYCLES = 240,
   parameter int unsigned PLL_TIMEOUT   = 24000,
   parameter int unsigned CDR_TIMEOUT   = 48000,
   parameter int unsigned ALIGN_TIMEOUT = 4800,
   parameter int unsigned MAX_RETRY     = 3,
   parameter int unsigned CNT_W         = 16
) (
   input  logic       clk_ref_24m,
   input  logic       rst,
   input  logic       phy_en,
   input  logic       por_complete,
   input  logic       pll_lock,
   input  logic       cdr_lock,
   input  logic       rx_aligned,
   output logic       pll_rst,
   output logic       cdr_rst,
   output logic       tx_en,
   output logic       rx_en,
   output logic       rx_align_rst,
   output logic       phy_ready,
   output logic [2:0] seq_state,
   output logic       seq_error,
   output logic [1:0] retry_cnt
);

   typedef enum logic [2:0] {
      S_OFF      = 3'd0,
      S_PLL_RST  = 3'd1,
      S_PLL_WAIT = 3'd2,
      S_CDR_RST  = 3'd3,
      S_CDR_WAIT = 3'd4,
      S_ALIGN    = 3'd5,
      S_READY    = 3'd6,
      S_FAULT    = 3'd7
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       retry_nxt;
   logic             err_nxt;
   logic             stage_timeout;
   logic             settle_done;

   // {pll_rst, cdr_rst, tx_en, rx_en, phy_ready} for a given state
   function automatic logic [4:0] decode(state_t s);
      case (s)
         S_PLL_WAIT:          decode = 5'b01000;
         S_CDR_RST:           decode = 5'b01100;
         S_CDR_WAIT, S_ALIGN: decode = 5'b00110;
         S_READY:             decode = 5'b00111;
         default:             decode = 5'b11000;
      endcase
   endfunction

   assign settle_done = (cnt == CNT_W'(SETTLE_CYCLES - 1));
   assign seq_state   = state;

   always_comb begin
      // NOTE: every signal gets a default up front so no path through the case leaves one unassigned (no latch).
      state_nxt     = state;
      retry_nxt     = retry_cnt;
      err_nxt       = seq_error;
      stage_timeout = 1'b0;

      if (!phy_en) begin
         state_nxt = S_OFF;
         retry_nxt = 2'd0;
         err_nxt   = 1'b0;
      end else begin
         case (state)
            S_OFF:     if (por_complete) state_nxt = S_PLL_RST;
            S_PLL_RST: if (settle_done) state_nxt = S_PLL_WAIT;
            S_PLL_WAIT: begin
               if (pll_lock) state_nxt = S_CDR_RST;
               else          stage_timeout = (cnt == CNT_W'(PLL_TIMEOUT - 1));
            end
            S_CDR_RST: if (settle_done) state_nxt = pll_lock ? S_CDR_WAIT : S_PLL_RST;
            S_CDR_WAIT: begin
               if (!pll_lock)     state_nxt = S_PLL_RST;
               else if (cdr_lock) state_nxt = S_ALIGN;
               else               stage_timeout = (cnt == CNT_W'(CDR_TIMEOUT - 1));
            end
            S_ALIGN: begin
               if (!pll_lock)       state_nxt = S_PLL_RST;
               else if (!cdr_lock)  state_nxt = S_CDR_RST;
               else if (rx_aligned) state_nxt = S_READY;
               else                 stage_timeout = (cnt == CNT_W'(ALIGN_TIMEOUT - 1));
            end
            S_READY: begin
               if (!pll_lock)      state_nxt = S_PLL_RST;
               else if (!cdr_lock) state_nxt = S_CDR_RST;
            end
            default: state_nxt = S_FAULT;
         endcase

         // Only a timeout consumes a retry; lock-loss re-entries are free.
         if (stage_timeout) begin
            retry_nxt = (retry_cnt == 2'd3) ? 2'd3 : retry_cnt + 2'd1;
            if ({1'b0, retry_cnt} + 3'd1 < 3'(MAX_RETRY)) begin
               state_nxt = S_PLL_RST;
            end else begin
               state_nxt = S_FAULT;
               err_nxt   = 1'b1;
            end
         end
      end
   end

   // Outputs are decoded from the next state so they switch on the same edge as seq_state.
   always_ff @(posedge clk_ref_24m) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state        <= S_OFF;
         cnt          <= '0;
         retry_cnt    <= 2'd0;
         seq_error    <= 1'b0;
         {pll_rst, cdr_rst, tx_en, rx_en, phy_ready} <= decode(S_OFF);
         rx_align_rst <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
         retry_cnt    <= retry_nxt;
         seq_error    <= err_nxt;
         {pll_rst, cdr_rst, tx_en, rx_en, phy_ready} <= decode(state_nxt);
         rx_align_rst <= (state_nxt == S_ALIGN) && (state != S_ALIGN);
      end
   end

endmodule

// File: tb/tb_serdesphy_link_seq.sv
// Directed bench for serdesphy_link_seq: expected states are queued as stimulus is driven
// and compared one clock later against every output.
module tb_serdesphy_link_seq;

   localparam logic [2:0] OFF = 3'd0, PLL_RST = 3'd1, PLL_WAIT = 3'd2, CDR_RST = 3'd3,
                          CDR_WAIT = 3'd4, ALIGN = 3'd5, READY = 3'd6, FAULT = 3'd7;

   logic       clk_ref_24m = 1'b0;
   logic       rst = 1'b1, phy_en = 1'b0, por_complete = 1'b0;
   logic       pll_lock = 1'b0, cdr_lock = 1'b0, rx_aligned = 1'b0;
   logic       pll_rst, cdr_rst, tx_en, rx_en, rx_align_rst, phy_ready, seq_error;
   logic [2:0] seq_state;
   logic [1:0] retry_cnt;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [2:0] st;
      logic       ars;
      logic [1:0] retry;
      logic       err;
   } exp_t;

   exp_t       sb_q[$];
   string      tag_q[$];
   logic [1:0] m_retry = 2'd0;
   logic       m_err   = 1'b0;

   serdesphy_link_seq #(
      .SETTLE_CYCLES(4), .PLL_TIMEOUT(16), .CDR_TIMEOUT(16),
      .ALIGN_TIMEOUT(8), .MAX_RETRY(2), .CNT_W(16)
   ) dut (
      .clk_ref_24m (clk_ref_24m),
      .rst         (rst),
      .phy_en      (phy_en),
      .por_complete(por_complete),
      .pll_lock    (pll_lock),
      .cdr_lock    (cdr_lock),
      .rx_aligned  (rx_aligned),
      .pll_rst     (pll_rst),
      .cdr_rst     (cdr_rst),
      .tx_en       (tx_en),
      .rx_en       (rx_en),
      .rx_align_rst(rx_align_rst),
      .phy_ready   (phy_ready),
      .seq_state   (seq_state),
      .seq_error   (seq_error),
      .retry_cnt   (retry_cnt)
   );

   always #5 clk_ref_24m = ~clk_ref_24m;

   // Reference output table {pll_rst, cdr_rst, tx_en, rx_en, phy_ready}
   function automatic logic [4:0] ref_outs(logic [2:0] s);
      case (s)
         PLL_WAIT:        return 5'b01000;
         CDR_RST:         return 5'b01100;
         CDR_WAIT, ALIGN: return 5'b00110;
         READY:           return 5'b00111;
         default:         return 5'b11000;
      endcase
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Queue the expectation for the coming edge, advance, then pop and compare.
   task automatic expect_step(input string tag, input logic [2:0] st, input logic ars);
      exp_t  e;
      string t;
      sb_q.push_back('{st: st, ars: ars, retry: m_retry, err: m_err});
      tag_q.push_back(tag);
      @(posedge clk_ref_24m);
      #1;
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check({t, ":state"}, 8'(seq_state), 8'(e.st));
      check({t, ":outs"}, 8'({pll_rst, cdr_rst, tx_en, rx_en, phy_ready}), 8'(ref_outs(e.st)));
      check({t, ":align_rst"}, 8'(rx_align_rst), 8'(e.ars));
      check({t, ":retry"}, 8'(retry_cnt), 8'(e.retry));
      check({t, ":error"}, 8'(seq_error), 8'(e.err));
   endtask

   task automatic walk(input string tag, input logic [2:0] st, input int n);
      for (int i = 0; i < n; i++) expect_step(tag, st, 1'b0);
   endtask

   initial begin
      // Reset and nominal bring-up
      expect_step("reset", OFF, 1'b0);
      rst = 1'b0; phy_en = 1'b1; por_complete = 1'b1;
      expect_step("t1_pll_rst", PLL_RST, 1'b0);
      por_complete = 1'b0;
      walk("t1_pll_rst_hold", PLL_RST, 3);
      expect_step("t1_pll_wait", PLL_WAIT, 1'b0);
      walk("t1_pll_wait_hold", PLL_WAIT, 4);
      pll_lock = 1'b1;
      expect_step("t1_cdr_rst", CDR_RST, 1'b0);
      walk("t1_cdr_rst_hold", CDR_RST, 3);
      expect_step("t1_cdr_wait", CDR_WAIT, 1'b0);
      walk("t1_cdr_wait_hold", CDR_WAIT, 2);
      cdr_lock = 1'b1;
      expect_step("t1_align", ALIGN, 1'b1);
      walk("t1_align_hold", ALIGN, 1);
      rx_aligned = 1'b1;
      expect_step("t1_ready", READY, 1'b0);
      walk("t1_ready_hold", READY, 2);

      // Lock loss while ready: CDR then PLL
      cdr_lock = 1'b0;
      expect_step("t3_cdr_loss", CDR_RST, 1'b0);
      cdr_lock = 1'b1;
      walk("t3_cdr_rst_hold", CDR_RST, 3);
      expect_step("t3_cdr_wait", CDR_WAIT, 1'b0);
      expect_step("t3_align", ALIGN, 1'b1);
      expect_step("t3_ready", READY, 1'b0);
      pll_lock = 1'b0;
      expect_step("t3_pll_loss", PLL_RST, 1'b0);
      pll_lock = 1'b1;
      walk("t3_pll_rst_hold", PLL_RST, 3);
      expect_step("t3_pll_wait", PLL_WAIT, 1'b0);
      expect_step("t3_cdr_rst", CDR_RST, 1'b0);
      walk("t3_cdr_rst_hold2", CDR_RST, 3);
      expect_step("t3_cdr_wait2", CDR_WAIT, 1'b0);
      expect_step("t3_align2", ALIGN, 1'b1);
      expect_step("t3_ready2", READY, 1'b0);

      // PLL never locks: one retry, then FAULT
      pll_lock = 1'b0; cdr_lock = 1'b0; rx_aligned = 1'b0; phy_en = 1'b0;
      expect_step("t2_off", OFF, 1'b0);
      phy_en = 1'b1; por_complete = 1'b1;
      expect_step("t2_pll_rst", PLL_RST, 1'b0);
      walk("t2_pll_rst_hold", PLL_RST, 3);
      walk("t2_pll_wait", PLL_WAIT, 16);
      m_retry = 2'd1;
      expect_step("t2_retry", PLL_RST, 1'b0);
      walk("t2_pll_rst_hold2", PLL_RST, 3);
      walk("t2_pll_wait2", PLL_WAIT, 16);
      m_retry = 2'd2; m_err = 1'b1;
      expect_step("t2_fault", FAULT, 1'b0);
      pll_lock = 1'b1; cdr_lock = 1'b1;
      walk("t2_fault_hold", FAULT, 3);
      phy_en = 1'b0; m_retry = 2'd0; m_err = 1'b0;
      expect_step("t2_fault_exit", OFF, 1'b0);
      pll_lock = 1'b0; cdr_lock = 1'b0;

      // phy_en drop in CDR_WAIT with a retry outstanding
      phy_en = 1'b1;
      expect_step("t4_pll_rst", PLL_RST, 1'b0);
      walk("t4_pll_rst_hold", PLL_RST, 3);
      walk("t4_pll_wait", PLL_WAIT, 16);
      m_retry = 2'd1;
      expect_step("t4_retry", PLL_RST, 1'b0);
      walk("t4_pll_rst_hold2", PLL_RST, 3);
      expect_step("t4_pll_wait2", PLL_WAIT, 1'b0);
      pll_lock = 1'b1;
      expect_step("t4_cdr_rst", CDR_RST, 1'b0);
      walk("t4_cdr_rst_hold", CDR_RST, 3);
      walk("t4_cdr_wait", CDR_WAIT, 2);
      phy_en = 1'b0; m_retry = 2'd0;
      expect_step("t4_off", OFF, 1'b0);

      // Lock arriving in the timeout cycle wins; rst from READY
      pll_lock = 1'b0; phy_en = 1'b1;
      expect_step("t5_pll_rst", PLL_RST, 1'b0);
      walk("t5_pll_rst_hold", PLL_RST, 3);
      walk("t5_pll_wait", PLL_WAIT, 16);
      pll_lock = 1'b1;
      expect_step("t5_lock_beats_timeout", CDR_RST, 1'b0);
      walk("t5_cdr_rst_hold", CDR_RST, 3);
      cdr_lock = 1'b1; rx_aligned = 1'b1;
      expect_step("t5_cdr_wait", CDR_WAIT, 1'b0);
      expect_step("t5_align", ALIGN, 1'b1);
      expect_step("t5_ready", READY, 1'b0);
      rst = 1'b1;
      expect_step("t5_rst_in_ready", OFF, 1'b0);
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
